// File: rtl/btn_pkg.sv
// Shared FSM state encodings, 25 MHz default timing constants and a small
// helper for the button conditioner.
package btn_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DB_PRESS = 2'd1;
    localparam logic [1:0] DOWN     = 2'd2;
    localparam logic [1:0] DB_REL   = 2'd3;

    localparam int unsigned DEF_N_BTN         = 3;
    localparam int unsigned DEF_DB_CYCLES     = 250000;    // 10 ms
    localparam int unsigned DEF_HOLD_CYCLES   = 25000000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES = 6250000;   // 250 ms
    localparam int unsigned DEF_CNT_W         = 25;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, press/release/hold pulses.
// Optional macro BTN_REPEAT_EN adds auto-repeat press pulses after a long press.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
`ifdef BTN_REPEAT_EN
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
`endif
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt;
`endif

    logic             sync1;
    logic             s;
    logic [1:0]       state;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic             hold_done;
    logic             active;

    assign active = (state == DOWN) || (state == DB_REL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            s         <= 1'b0;
            state     <= IDLE;
            dcnt      <= '0;
            hcnt      <= '0;
            hold_done <= 1'b0;
            level     <= 1'b0;
            pressed   <= 1'b0;
            released  <= 1'b0;
            held      <= 1'b0;
`ifdef BTN_REPEAT_EN
            rcnt      <= '0;
`endif
        end else begin
            sync1    <= raw;
            s        <= sync1;
            pressed  <= 1'b0;
            released <= 1'b0;
            held     <= 1'b0;

            // Hold timing runs through release debounce so a press that
            // bounces back to DOWN keeps its accumulated hold time.
            if (active) begin
                if (hcnt != HOLD_LAST) hcnt <= hcnt + 1'b1;
                if (hcnt == HOLD_LAST && !hold_done) begin
                    held      <= 1'b1;
                    hold_done <= 1'b1;
                end
            end

`ifdef BTN_REPEAT_EN
            if (active && hold_done) begin
                if (rcnt == REP_LAST) begin
                    rcnt    <= '0;
                    pressed <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
`endif

            case (state)
                IDLE: begin
                    if (s) begin
                        state <= DB_PRESS;
                        dcnt  <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (dcnt == DB_LAST) begin
                        state     <= DOWN;
                        pressed   <= 1'b1;
                        level     <= 1'b1;
                        hcnt      <= '0;
                        hold_done <= 1'b0;
`ifdef BTN_REPEAT_EN
                        rcnt      <= '0;
`endif
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (!s) begin
                        state <= DB_REL;
                        dcnt  <= '0;
                    end
                end
                DB_REL: begin
                    if (s) begin
                        state <= DOWN;
                    end else if (dcnt == DB_LAST) begin
                        // Release wins over a repeat landing on the same edge.
                        state    <= IDLE;
                        released <= 1'b1;
                        pressed  <= 1'b0;
                        level    <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: N_BTN independent btn_channel instances.
// Optional macro BTN_REPEAT_EN enables auto-repeat press pulses after a long press.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN         = DEF_N_BTN,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    localparam int unsigned     MAX_CYCLES = max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam longint unsigned CNT_MAX    = (64'd1 << CNT_W) - 64'd1;

    if (DB_CYCLES < 2 || HOLD_CYCLES < 2 || 64'(MAX_CYCLES) > CNT_MAX) begin : g_bad_cfg
        $error("button_conditioner: cycle counts below 2 or too wide for CNT_W");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
`ifdef BTN_REPEAT_EN
            .REPEAT_CYCLES (REPEAT_CYCLES),
`endif
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (btn_raw[i]),
            .level    (btn_level[i]),
            .pressed  (btn_press[i]),
            .released (btn_release[i]),
            .held     (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DB=4, HOLD=20, REPEAT=8, 3 channels).
module tb_button_conditioner;

    localparam int N = 3;
`ifdef BTN_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_hold;

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;
    int b2b      = 0;
    int e0;
    int e1;

    int n_press[N];
    int n_rel[N];
    int n_hold[N];
    int e_press[N];
    int e_rel[N];
    int e_hold[N];
    int e_rise[N];
    int e_fall[N];
    logic [N-1:0] prev_level = '0;
    logic [N-1:0] prev_press = '0;
    logic [N-1:0] prev_rel   = '0;
    logic [N-1:0] prev_hold  = '0;

    button_conditioner #(
        .N_BTN         (3),
        .DB_CYCLES     (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount = ecount + 1;

    // Pulse/level event recorder, sampled mid-cycle; edges are tagged with ecount.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (btn_press[c]) begin
                n_press[c]++;
                if (e_press[c] < 0) e_press[c] = ecount;
            end
            if (btn_release[c]) begin
                n_rel[c]++;
                if (e_rel[c] < 0) e_rel[c] = ecount;
            end
            if (btn_hold[c]) begin
                n_hold[c]++;
                if (e_hold[c] < 0) e_hold[c] = ecount;
            end
            if (btn_level[c] && !prev_level[c] && e_rise[c] < 0) e_rise[c] = ecount;
            if (!btn_level[c] && prev_level[c] && e_fall[c] < 0) e_fall[c] = ecount;
            if ((btn_press[c] && prev_press[c]) || (btn_release[c] && prev_rel[c]) ||
                (btn_hold[c] && prev_hold[c]))
                b2b++;
        end
        prev_level = btn_level;
        prev_press = btn_press;
        prev_rel   = btn_release;
        prev_hold  = btn_hold;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < N; c++) begin
            n_press[c] = 0;
            n_rel[c]   = 0;
            n_hold[c]  = 0;
            e_press[c] = -1;
            e_rel[c]   = -1;
            e_hold[c]  = -1;
            e_rise[c]  = -1;
            e_fall[c]  = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({btn_level, btn_press, btn_release, btn_hold}), 0);
        rst = 1'b1;
        tick();

        // Clean press on channel 0
        clr();
        btn_raw[0] = 1'b1;
        e0 = ecount + 1;
        repeat (40) tick();
        check("t1_press_cnt", n_press[0], 1 + REP);
        check("t1_press_edge", e_press[0], e0 + 6);
        check("t1_level_rise", e_rise[0], e0 + 6);
        check("t1_hold_edge", e_hold[0], e0 + 26);
        check("t1_level_held", int'(btn_level[0]), 1);
        btn_raw[0] = 1'b0;
        e1 = ecount + 1;
        repeat (12) tick();
        check("t1_release_cnt", n_rel[0], 1);
        check("t1_release_edge", e_rel[0], e1 + 6);
        check("t1_level_fall", e_fall[0], e1 + 6);
        check("t1_others_silent",
              n_press[1] + n_press[2] + n_rel[1] + n_rel[2] + n_hold[1] + n_hold[2], 0);

        // Bounce on channel 1
        clr();
        for (int i = 0; i < 12; i++) begin
            btn_raw[1] = ((i / 2) % 2 == 0);
            tick();
        end
        check("t2_quiet_bouncing", n_press[1] + n_rel[1] + n_hold[1] + int'(btn_level[1]), 0);
        btn_raw[1] = 1'b1;
        e0 = ecount + 1;
        repeat (10) tick();
        check("t2_press_cnt", n_press[1], 1);
        check("t2_press_edge", e_press[1], e0 + 6);
        btn_raw[1] = 1'b0;
        repeat (10) tick();
        check("t2_release_cnt", n_rel[1], 1);

        // Short release glitch on channel 0 while DOWN
        btn_raw[0] = 1'b1;
        repeat (10) tick();
        clr();
        btn_raw[0] = 1'b0;
        repeat (2) tick();
        btn_raw[0] = 1'b1;
        repeat (12) tick();
        check("t3_no_release", n_rel[0], 0);
        check("t3_no_press", n_press[0], 0);
        check("t3_level_kept", int'(btn_level[0]), 1);
        btn_raw[0] = 1'b0;
        repeat (12) tick();

        // Long press on channel 2
        clr();
        btn_raw[2] = 1'b1;
        e0 = ecount + 1;
        repeat (60) tick();
        btn_raw[2] = 1'b0;
        repeat (12) tick();
        check("t4_press_edge", e_press[2], e0 + 6);
        check("t4_hold_cnt", n_hold[2], 1);
        check("t4_hold_edge", e_hold[2], e0 + 26);
        check("t4_press_cnt", n_press[2], 1 + 4 * REP);
        check("t4_release_edge", e_rel[2], e0 + 66);

        // Simultaneous presses on channels 0 and 2
        clr();
        btn_raw = 3'b101;
        e0 = ecount + 1;
        repeat (10) tick();
        check("t5_press0_edge", e_press[0], e0 + 6);
        check("t5_press2_edge", e_press[2], e0 + 6);
        check("t5_press1_silent", n_press[1], 0);
        btn_raw = '0;
        e1 = ecount + 1;
        repeat (10) tick();
        check("t5_rel0_edge", e_rel[0], e1 + 6);
        check("t5_rel2_edge", e_rel[2], e1 + 6);

        // Reset while channel 0 is DOWN with hcnt=10
        clr();
        btn_raw[0] = 1'b1;
        e0 = ecount + 1;
        repeat (17) tick();
        check("t6_level_before", int'(btn_level[0]), 1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_clear", int'({btn_level, btn_press, btn_release, btn_hold}), 0);
        tick();
        tick();
        rst = 1'b1;
        e1 = ecount + 1;
        clr();
        repeat (30) tick();
        check("t6_fresh_press_edge", e_press[0], e1 + 6);
        check("t6_hold_restart_edge", e_hold[0], e1 + 26);
        btn_raw[0] = 1'b0;
        repeat (12) tick();
        check("t6_release_cnt", n_rel[0], 1);

        check("no_back_to_back", b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
